// File: rtl/l1_conditioner.sv
// Per-channel L1 front end: synchronize raw SURF L1 bits, turn rising edges into
// fixed-width pulses followed by a holdoff window, and flag channels stuck high.
module l1_conditioner #(
  parameter int NUM_SURFS   = 12,
  parameter int NUM_TRIG    = 4,
  parameter int STRETCH     = 4,
  parameter int HOLDOFF     = 8,
  parameter int STUCK_LIMIT = 1024,
  parameter bit AUTOMASK    = 1'b1
) (
  input  logic                          clk250_i,
  input  logic                          rst_i,
  input  logic [NUM_SURFS*NUM_TRIG-1:0] L1_i,
  input  logic [NUM_SURFS*NUM_TRIG-1:0] mask_i,
  output logic [NUM_SURFS*NUM_TRIG-1:0] L1_o,
  output logic [NUM_SURFS*NUM_TRIG-1:0] stuck_o,
  output logic                          any_o
);

  localparam int N       = NUM_SURFS * NUM_TRIG;
  localparam int CNT_MAX = (STRETCH > HOLDOFF) ? STRETCH : HOLDOFF;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;
  localparam int STK_W   = $clog2(STUCK_LIMIT + 1);

  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(STRETCH - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);
  localparam logic [STK_W-1:0] STK_ONE    = STK_W'(1);
  localparam logic [STK_W-1:0] STK_LIM    = STK_W'(STUCK_LIMIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  function automatic logic [STK_W-1:0] sat_inc(input logic [STK_W-1:0] v);
    return (v == STK_LIM) ? v : v + STK_ONE;
  endfunction

  logic [N-1:0] sync_p0;
  logic [N-1:0] sync_p1;
  logic [N-1:0] sync_p2;
  logic [N-1:0] rise_p3;
  logic [N-1:0] armed;
  logic [1:0]   fill;
  logic [N-1:0] eff_mask;

  // Stages p0..p2: three-flop synchronizer; p3: registered rising edge.
  // A channel only arms once it has been seen low after reset, so a level
  // still high across reset release never fakes an edge.
  always_ff @(posedge clk250_i or posedge rst_i) begin
    if (rst_i) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      sync_p2 <= '0;
      rise_p3 <= '0;
      armed   <= '0;
      fill    <= '0;
    end else begin
      sync_p0 <= L1_i;
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;
      rise_p3 <= sync_p1 & ~sync_p2 & armed;
      if (fill != 2'd2) fill <= fill + 2'd1;
      if (fill == 2'd2) armed <= armed | ~sync_p1;
    end
  end

  assign eff_mask = mask_i | ({N{AUTOMASK}} & stuck_o);

  for (genvar i = 0; i < N; i++) begin : g_chan
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             pulse;
    logic [STK_W-1:0] run;
    logic             stuck;

    // Stage p4: pulse/holdoff FSM with registered pulse output.
    always_ff @(posedge clk250_i or posedge rst_i) begin
      if (rst_i) begin
        state <= IDLE;
        cnt   <= '0;
        pulse <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (rise_p3[i] && !eff_mask[i]) begin
              state <= PULSE;
              cnt   <= PULSE_LOAD;
              pulse <= 1'b1;
            end
          end
          PULSE: begin
            if (eff_mask[i]) begin
              state <= IDLE;
              cnt   <= '0;
              pulse <= 1'b0;
            end else if (cnt == '0) begin
              pulse <= 1'b0;
              if (HOLDOFF == 0) begin
                state <= IDLE;
              end else begin
                state <= HOLD;
                cnt   <= HOLD_LOAD;
              end
            end else begin
              cnt <= cnt - CNT_ONE;
            end
          end
          HOLD: begin
            if (eff_mask[i] || cnt == '0) begin
              state <= IDLE;
              cnt   <= '0;
            end else begin
              cnt <= cnt - CNT_ONE;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
            pulse <= 1'b0;
          end
        endcase
      end
    end

    // Stage p2 -> stuck flag: saturating run length of synchronized-high cycles.
    always_ff @(posedge clk250_i or posedge rst_i) begin
      if (rst_i) begin
        run   <= '0;
        stuck <= 1'b0;
      end else if (sync_p1[i]) begin
        run   <= sat_inc(run);
        stuck <= (sat_inc(run) == STK_LIM);
      end else begin
        run   <= '0;
        stuck <= 1'b0;
      end
    end

    assign L1_o[i]    = pulse;
    assign stuck_o[i] = stuck;
  end

  always_ff @(posedge clk250_i or posedge rst_i) begin
    if (rst_i) any_o <= 1'b0;
    else       any_o <= |L1_o;
  end

endmodule

// File: tb/tb_l1_conditioner.sv
// Scoreboard bench for l1_conditioner: directed scenarios plus random traffic,
// checked every cycle against an event-time reference model.
module tb_l1_conditioner;

  localparam int NUM_SURFS   = 12;
  localparam int NUM_TRIG    = 4;
  localparam int N           = NUM_SURFS * NUM_TRIG;
  localparam int STRETCH     = 4;
  localparam int HOLDOFF     = 8;
  localparam int STUCK_LIMIT = 16;
  localparam bit AUTOMASK    = 1'b1;
  localparam longint NONE    = -1000;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] l1_in = '0;
  logic [N-1:0] mask = '0;
  logic [N-1:0] l1_out;
  logic [N-1:0] stuck;
  logic         any;

  l1_conditioner #(
    .NUM_SURFS(NUM_SURFS), .NUM_TRIG(NUM_TRIG), .STRETCH(STRETCH),
    .HOLDOFF(HOLDOFF), .STUCK_LIMIT(STUCK_LIMIT), .AUTOMASK(AUTOMASK)
  ) dut (
    .clk250_i(clk), .rst_i(rst), .L1_i(l1_in), .mask_i(mask),
    .L1_o(l1_out), .stuck_o(stuck), .any_o(any)
  );

  always #2 clk = ~clk;

  typedef struct {
    logic [N-1:0] l1;
    logic [N-1:0] stk;
    logic         any;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  // Reference model: sample history, pulse start times and high-run lengths.
  logic [4:0]   smp [N];
  int           run [N];
  bit           stkv [N];
  longint       ps [N];
  logic [N-1:0] m_out = '0;
  logic         m_any = 1'b0;
  int           nrel = 0;
  longint       k = 0;

  logic [N-1:0] cur_l1 = '0;
  logic [N-1:0] cur_mask = '0;
  logic         cur_rst = 1'b1;

  task automatic model_edge(input logic [N-1:0] din, input logic [N-1:0] dm, input logic drst);
    exp_t e;
    bit   s2, em, acc, idle;
    k++;
    if (drst) begin
      nrel  = 0;
      m_out = '0;
      m_any = 1'b0;
      for (int c = 0; c < N; c++) begin
        smp[c] = '0; run[c] = 0; stkv[c] = 1'b0; ps[c] = NONE;
      end
    end else begin
      m_any = |m_out;
      if (nrel < 10) nrel++;
      for (int c = 0; c < N; c++) begin
        smp[c] = {smp[c][3:0], din[c]};
        s2   = (nrel >= 3) && smp[c][2];
        em   = dm[c] | (AUTOMASK & stkv[c]);
        acc  = (nrel >= 5) && smp[c][3] && !smp[c][4];
        idle = (ps[c] == NONE) || (k > ps[c] + STRETCH + HOLDOFF);
        if (!idle && em) ps[c] = NONE;
        else if (idle && acc && !em) ps[c] = k;
        m_out[c] = (ps[c] != NONE) && (k >= ps[c]) && (k <= ps[c] + STRETCH - 1);
        run[c]  = s2 ? ((run[c] < STUCK_LIMIT) ? run[c] + 1 : STUCK_LIMIT) : 0;
        stkv[c] = (run[c] == STUCK_LIMIT);
      end
    end
    e.l1 = m_out;
    for (int c = 0; c < N; c++) e.stk[c] = stkv[c];
    e.any = m_any;
    q.push_back(e);
  endtask

  task automatic cyc(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      @(negedge clk);
      l1_in = cur_l1;
      mask  = cur_mask;
      if (cur_rst && !rst) begin
        rst = 1'b1;
        #1;
        total++;
        if (l1_out !== '0 || stuck !== '0 || any !== 1'b0) begin
          bad++;
          $display("FAIL rst_async t=%0t got l1=%h stuck=%h any=%b want all zero", $time, l1_out, stuck, any);
        end
      end else begin
        rst = cur_rst;
      end
      model_edge(cur_l1, cur_mask, cur_rst);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      total++;
      if (l1_out !== e.l1 || stuck !== e.stk || any !== e.any) begin
        bad++;
        $display("FAIL cycle t=%0t l1 got %h want %h stuck got %h want %h any got %b want %b",
                 $time, l1_out, e.l1, stuck, e.stk, any, e.any);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int rst_hold;
    rst_hold = 0;
    cur_rst = 1'b1; cyc(3);
    cur_rst = 1'b0; cyc(10);

    // single pulse on ch0
    cur_l1[0] = 1'b1; cyc(2); cur_l1[0] = 1'b0; cyc(25);

    // holdoff on ch5: edges at 0, 6, 20
    cur_l1[5] = 1'b1; cyc(2); cur_l1[5] = 1'b0; cyc(4);
    cur_l1[5] = 1'b1; cyc(2); cur_l1[5] = 1'b0; cyc(12);
    cur_l1[5] = 1'b1; cyc(2); cur_l1[5] = 1'b0; cyc(25);

    // mask ch3 on second pulse cycle, edge while masked, then unmask + edge
    cur_l1[3] = 1'b1; cyc(2); cur_l1[3] = 1'b0; cyc(3);
    cur_mask[3] = 1'b1; cyc(5);
    cur_l1[3] = 1'b1; cyc(2); cur_l1[3] = 1'b0; cyc(20);
    cur_mask[3] = 1'b0; cyc(3);
    cur_l1[3] = 1'b1; cyc(2); cur_l1[3] = 1'b0; cyc(25);

    // stuck ch7, brief drop, re-rise
    cur_l1[7] = 1'b1; cyc(30); cur_l1[7] = 1'b0; cyc(1);
    cur_l1[7] = 1'b1; cyc(20); cur_l1[7] = 1'b0; cyc(25);

    // all channels together
    cur_l1 = '1; cyc(3); cur_l1 = '0; cyc(25);

    // reset mid-pulse with stuck channel, release with inputs still high
    cur_l1[9] = 1'b1; cyc(18);
    cur_l1[1] = 1'b1; cyc(4);
    cur_rst = 1'b1; cyc(2);
    cur_rst = 1'b0; cyc(15);
    cur_l1 = '0; cyc(3);
    cur_l1[1] = 1'b1; cyc(2); cur_l1[1] = 1'b0; cyc(25);

    // random traffic with occasional mask changes and resets
    for (int t = 0; t < 1500; t++) begin
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(0, 15) == 0) cur_l1[c] = ~cur_l1[c];
        if ($urandom_range(0, 63) == 0) cur_mask[c] = ~cur_mask[c];
      end
      if (rst_hold > 0) rst_hold--;
      else if ($urandom_range(0, 599) == 0) rst_hold = 2;
      cur_rst = (rst_hold > 0);
      cyc(1);
    end

    cur_l1 = '0; cur_mask = '0; cur_rst = 1'b0; cyc(5);
    @(posedge clk);
    #2;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
